// File: rtl/abp_pkg.sv
// Shared definitions for the Alternating Bit Protocol receive path.
package abp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECEIVE,
    DRAIN,
    CHECK,
    READOUT,
    ACK
  } abp_rx_state_t;

  // Position of the sequence bit inside the header byte.
  localparam int SEQ_BIT_POS = 0;

  typedef enum logic {
    ERR_SHORT,
    ERR_OVERSIZE
  } abp_frame_err_t;

endpackage

// File: rtl/abp_frame_receiver_bram.sv
// Single-port frame buffer with registered read (read-before-write).
module abp_frame_receiver_bram #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     aclk,
  input  logic                     we,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];

  always_ff @(posedge aclk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/abp_frame_receiver.sv
// ABP receiver: buffers one frame, checks its sequence bit, delivers fresh payloads and acks every good frame.
module abp_frame_receiver
  import abp_pkg::*;
#(
  parameter int   VALUE_BYTES   = 8,
  parameter int   MAX_FRAME     = 64,
  parameter logic INIT_EXPECTED = 1'b0
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  input  logic [7:0]               s_axis_tdata,
  output logic [8*VALUE_BYTES-1:0] value,
  output logic                     value_valid,
  output logic                     ack_valid,
  input  logic                     ack_ready,
  output logic                     ack_bit,
  output logic                     expected_bit,
  output logic                     busy,
  output logic                     frame_err
);

  localparam int AW = $clog2(MAX_FRAME);
  localparam logic [AW:0] PAYLOAD_END = (AW+1)'(VALUE_BYTES);
  localparam logic [AW:0] LAST_SLOT   = (AW+1)'(MAX_FRAME - 1);

  abp_rx_state_t state_reg, state_next;
  logic [AW:0]   idx_reg, idx_next;
  logic [AW:0]   rd_cnt_reg, rd_cnt_next;
  logic          hdr_bit_reg, hdr_bit_next;
  logic          expected_reg, expected_next;
  logic          frame_err_reg, frame_err_next;
  logic [8*VALUE_BYTES-1:0] value_reg;
  logic [8*VALUE_BYTES-1:0] assembled;
  logic [7:0]    lane_reg [VALUE_BYTES];

  logic          rx_open;
  logic          beat;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [7:0]    bram_rdata;

  // Held low during reset so the upstream sees no readiness until the engine is live.
  assign rx_open = aresetn && (state_reg == IDLE || state_reg == RECEIVE || state_reg == DRAIN);
  assign beat    = s_axis_tvalid && rx_open;

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    rd_cnt_next    = rd_cnt_reg;
    hdr_bit_next   = hdr_bit_reg;
    expected_next  = expected_reg;
    frame_err_next = 1'b0;
    bram_we        = 1'b0;
    bram_addr      = idx_reg[AW-1:0];
    value_valid    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        bram_addr = '0;
        if (beat) begin
          bram_we      = 1'b1;
          hdr_bit_next = s_axis_tdata[SEQ_BIT_POS];
          idx_next     = (AW+1)'(1);
          if (s_axis_tlast) frame_err_next = 1'b1;
          else              state_next     = RECEIVE;
        end
      end
      RECEIVE: begin
        if (beat) begin
          bram_we  = 1'b1;
          idx_next = idx_reg + 1'b1;
          if (s_axis_tlast) begin
            // Frame length is idx_reg + 1; it must cover header plus full payload.
            if (idx_reg < PAYLOAD_END) begin
              frame_err_next = 1'b1;
              state_next     = IDLE;
            end else begin
              state_next = CHECK;
            end
          end else if (idx_reg == LAST_SLOT) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (beat && s_axis_tlast) begin
          frame_err_next = 1'b1;
          state_next     = IDLE;
        end
      end
      CHECK: begin
        rd_cnt_next = '0;
        state_next  = (hdr_bit_reg == expected_reg) ? READOUT : ACK;
      end
      READOUT: begin
        bram_addr   = rd_cnt_reg[AW-1:0] + AW'(1);
        rd_cnt_next = rd_cnt_reg + 1'b1;
        if (rd_cnt_reg == PAYLOAD_END) begin
          value_valid   = 1'b1;
          expected_next = ~expected_reg;
          state_next    = ACK;
        end
      end
      ACK: begin
        if (ack_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      rd_cnt_reg    <= '0;
      hdr_bit_reg   <= 1'b0;
      expected_reg  <= INIT_EXPECTED;
      frame_err_reg <= 1'b0;
      value_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      rd_cnt_reg    <= rd_cnt_next;
      hdr_bit_reg   <= hdr_bit_next;
      expected_reg  <= expected_next;
      frame_err_reg <= frame_err_next;
      if (value_valid) value_reg <= assembled;
    end
  end

  // Read data for address k appears when rd_cnt_reg == k; park it in lane k-1.
  always_ff @(posedge aclk) begin
    if (state_reg == READOUT) begin
      for (int i = 0; i < VALUE_BYTES; i++) begin
        if (rd_cnt_reg == (AW+1)'(i + 1)) lane_reg[i] <= bram_rdata;
      end
    end
  end

  // The top lane bypasses straight from the BRAM so value is complete in the value_valid cycle.
  for (genvar gi = 0; gi < VALUE_BYTES; gi++) begin : g_lane
    if (gi == VALUE_BYTES - 1) begin : g_top
      assign assembled[8*gi +: 8] = bram_rdata;
    end else begin : g_low
      assign assembled[8*gi +: 8] = lane_reg[gi];
    end
  end

  abp_frame_receiver_bram #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (8)
  ) u_bram (
    .aclk  (aclk),
    .we    (bram_we),
    .addr  (bram_addr),
    .wdata (s_axis_tdata),
    .rdata (bram_rdata)
  );

  assign s_axis_tready = rx_open;
  assign value         = value_valid ? assembled : value_reg;
  assign ack_valid     = (state_reg == ACK);
  assign ack_bit       = ack_valid & hdr_bit_reg;
  assign expected_bit  = expected_reg;
  assign busy          = (state_reg != IDLE);
  assign frame_err     = frame_err_reg;

endmodule

// File: doc/abp_frame_receiver.md
# abp_frame_receiver

Parametrised receiver-side frame engine for the Alternating Bit Protocol. It accepts one byte-wide AXI-Stream frame at a time and buffers it in a BRAM. It checks the frame's sequence bit against an internally tracked expected bit and extracts a VALUE_BYTES-wide little-endian payload. It delivers fresh frames to downstream logic and emits an acknowledge for both fresh and duplicate frames, sitting between the link deframer and the ABP acknowledge transmitter.

## Interface
- VALUE_BYTES, default 8: payload bytes extracted per frame; 1..MAX_FRAME-1.
- MAX_FRAME, default 64: buffer depth in bytes; power of two; BRAM address width is log2(MAX_FRAME).
- INIT_EXPECTED, default 1'b0: expected sequence bit after reset.
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_tvalid / s_axis_tready / s_axis_tlast  in/out/in  1  AXI-Stream frame input.
- s_axis_tdata  in  8  frame byte; byte 0 is the header, header bit 0 is the sequence bit; bytes 1..VALUE_BYTES are the payload, LSB byte first.
- value  out  8*VALUE_BYTES  last delivered payload, held until the next delivery.
- value_valid  out  1  one-cycle pulse when value updates.
- ack_valid / ack_ready  out/in  1  acknowledge handshake.
- ack_bit  out  1  sequence bit being acknowledged; stable while ack_valid is high.
- expected_bit  out  1  current expected sequence bit.
- busy  out  1  high in every state except IDLE.
- frame_err  out  1  one-cycle pulse on a dropped frame (short or oversize).

## Operation
- States: IDLE, RECEIVE, DRAIN, CHECK, READOUT, ACK.
- IDLE: tready=1. On an accepted beat, write the byte at address 0, latch the header bit, and set idx=1.
  - If tlast is on that beat: frame_err pulse, go to IDLE.
  - Otherwise go to RECEIVE.
- RECEIVE: tready=1. Each accepted beat writes BRAM[idx] and increments idx.
  - tlast with total length < 1+VALUE_BYTES: frame_err, go to IDLE.
  - tlast otherwise: go to CHECK.
  - idx reaches MAX_FRAME without tlast: stop writing, go to DRAIN.
- DRAIN: tready=1, no writes. Consume beats until tlast, then frame_err and go to IDLE. Oversize frames are never acked.
- CHECK: one cycle.
  - Header bit == expected_bit: go to READOUT.
  - Otherwise (duplicate): go to ACK with no delivery.
- READOUT: issue read addresses 1..VALUE_BYTES on consecutive cycles. With 1-cycle BRAM latency, byte k lands in value[8k-1:8(k-1)] one cycle after its address. When the last byte lands:
  - pulse value_valid;
  - toggle expected_bit;
  - go to ACK.
- ACK: ack_valid=1 and ack_bit=header bit. On ack_ready go to IDLE; ack_valid drops the next cycle.
- tready=0 in CHECK, READOUT and ACK. A new frame waits in the upstream.
- Bytes beyond VALUE_BYTES in a valid-length frame are stored but ignored.
- Arithmetic: idx is log2(MAX_FRAME)+1 bits, so it never wraps; length compares are unsigned.

## Timing
- Reset: all outputs 0 except expected_bit=INIT_EXPECTED; state IDLE; value=0.
- Reset mid-frame: the frame is abandoned. The rest of that frame arriving after reset is treated as a new frame.
- Latency for a fresh frame: tlast beat accepted at cycle T.
  - CHECK at T+1.
  - READOUT spans T+2..T+2+VALUE_BYTES.
  - value_valid at T+2+VALUE_BYTES.
  - ack_valid from T+3+VALUE_BYTES.
- Duplicate: ack_valid from T+2.
- tvalid low mid-frame: hold state; no timeout.
- ack_ready held high: ACK lasts exactly one cycle.

## Structure
- Shared package abp_pkg: state enum abp_rx_state_t, header sequence-bit position constant, frame_err cause enum (short, oversize) for the bench.
- One sub-module: the existing bram (ADDRESS_WIDTH=log2(MAX_FRAME), DATA_WIDTH=8), single port, registered read.

## Test plan
- Defaults, frame {0x00, 0x11..0x88}, ack_ready=1 -> value=0x8877665544332211, one value_valid pulse, ack_bit=0, expected_bit becomes 1.
- Same frame repeated -> no value_valid, value unchanged, ack with ack_bit=0, expected_bit stays 1.
- Frame of 5 bytes with header bit 1 -> frame_err pulse, no ack, expected_bit unchanged.
- 70-byte frame -> DRAIN consumes all 70 beats, one frame_err pulse, no ack, next valid frame processed normally.
- ack_ready held low 10 cycles -> ack_valid and ack_bit stable, tready=0 throughout, a back-to-back frame is accepted only after the handshake.
- VALUE_BYTES=2, MAX_FRAME=16, aresetn pulsed mid-frame -> all outputs reset, expected_bit=INIT_EXPECTED, the following frame {0x01,0xAA,0xBB} is treated as a duplicate and acked with ack_bit=1.
